inv_round: RTL and testbench

Single AES-128 decryption (inverse cipher) round, the decrypt-side counterpart of the encryption round: InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns, per FIPS-197 §5.3. It sits in the decrypt datapath between the inverse key schedule, which supplies `sub_key`, and the next inverse round or output register. It is fully pipelined: three register stages, one new block accepted per cycle, fixed latency.

---
 rtl/inv_round.sv | 165 ++++++++++++++++
 tb/tb_inv_round.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_round.sv
// -----------------------------------------------------------------------------
// inv_round: one AES-128 inverse cipher round, fully pipelined over three
// register stages (InvShiftRows+InvSubBytes -> AddRoundKey -> InvMixColumns).
// One beat per cycle, fixed three-register latency, no backpressure.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset, clears every pipeline flop
//   data_valid_in  data_in valid this cycle
//   data_in        input state, byte k = bits [127-8k -: 8], s[r,c] = byte 4c+r
//   key_valid_in   sub_key valid this cycle
//   sub_key        round key travelling with the beat
//   final_round    (only with INV_ROUND_FINAL_EN) skip InvMixColumns for this beat
//   valid_out      data_out valid
//   data_out       round result
//
// Build option: define INV_ROUND_FINAL_EN to add the final_round bypass input.
// -----------------------------------------------------------------------------
module inv_round #(
  parameter int unsigned DATA_LEN = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                key_valid_in,
  input  logic [DATA_LEN-1:0] sub_key,
`ifdef INV_ROUND_FINAL_EN
  input  logic                final_round,
`endif
  output logic                valid_out,
  output logic [DATA_LEN-1:0] data_out
);

  localparam int unsigned NB = DATA_LEN / 8;

  // GF(2^8) multiply by x, reduced with 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) shift-and-add multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 naturally).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // InvShiftRows followed by InvSubBytes: row r rotates right by r.
  function automatic logic [DATA_LEN-1:0] inv_shift_sub(input logic [DATA_LEN-1:0] s);
    logic [DATA_LEN-1:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[DATA_LEN-1-8*(4*c+r) -: 8] = inv_sbox(s[DATA_LEN-1-8*src -: 8]);
      end
    end
    return o;
  endfunction

  // InvMixColumns with coefficients 0e 0b 0d 09 rotated per row.
  function automatic logic [DATA_LEN-1:0] inv_mix(input logic [DATA_LEN-1:0] s);
    logic [DATA_LEN-1:0] o;
    logic [7:0] a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[DATA_LEN-1-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
        o[DATA_LEN-1-8*(4*c+r) -: 8] = gf_mul(8'h0e, a[r])
                                     ^ gf_mul(8'h0b, a[(r+1)%4])
                                     ^ gf_mul(8'h0d, a[(r+2)%4])
                                     ^ gf_mul(8'h09, a[(r+3)%4]);
      end
    end
    return o;
  endfunction

  // Bypass flag source; tied low when the option is not built.
  logic final_in;
`ifdef INV_ROUND_FINAL_EN
  assign final_in = final_round;
`else
  assign final_in = 1'b0;
`endif

  logic                s1_valid_q, s1_valid_d;
  logic [DATA_LEN-1:0] s1_data_q,  s1_data_d;
  logic [DATA_LEN-1:0] s1_key_q,   s1_key_d;
  logic                s1_final_q, s1_final_d;
  logic                s2_valid_q, s2_valid_d;
  logic [DATA_LEN-1:0] s2_data_q,  s2_data_d;
  logic                s2_final_q, s2_final_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q,  out_data_d;

  // Next-state for all stages; data loads every cycle, only valids gate.
  always_comb begin
    s1_valid_d  = data_valid_in && key_valid_in;
    s1_data_d   = inv_shift_sub(data_in);
    s1_key_d    = sub_key;
    s1_final_d  = final_in;
    s2_valid_d  = s1_valid_q;
    s2_data_d   = s1_data_q ^ s1_key_q;
    s2_final_d  = s1_final_q;
    out_valid_d = s2_valid_q;
    out_data_d  = s2_final_q ? s2_data_q : inv_mix(s2_data_q);
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_key_q    <= '0;
      s1_final_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_final_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_key_q    <= s1_key_d;
      s1_final_q  <= s1_final_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_final_q  <= s2_final_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign valid_out = out_valid_q;
  assign data_out  = out_data_q;

endmodule

// File: tb/tb_inv_round.sv
// -----------------------------------------------------------------------------
// tb_inv_round: self-checking bench for inv_round. Known-answer vectors from a
// table, hand-written reset/handshake sequences, and random traffic compared
// against a byte-level reference model with a three-deep expectation delay line.
// Define INV_ROUND_FINAL_EN for both files to exercise the bypass input.
// -----------------------------------------------------------------------------
module tb_inv_round;

  localparam int unsigned DL = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          dv, kv, fin;
  logic [DL-1:0] din, key;
  logic          vout;
  logic [DL-1:0] dout;

  always #5 clk = ~clk;

  inv_round #(.DATA_LEN(DL)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_valid_in (dv),
    .data_in       (din),
    .key_valid_in  (kv),
    .sub_key       (key),
`ifdef INV_ROUND_FINAL_EN
    .final_round   (fin),
`endif
    .valid_out     (vout),
    .data_out      (dout)
  );

  typedef struct packed {
    logic          valid;
    logic [DL-1:0] data;
  } exp_t;

  typedef struct packed {
    logic [DL-1:0] data;
    logic [DL-1:0] key;
    logic          fin;
    logic [DL-1:0] exp;
  } vec_t;

  exp_t       hist[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sbox_f [256];
  logic [7:0] sbox_i [256];

  // Carry-less product followed by reduction modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Forward S-box by brute-force inverse plus affine map, then invert the table.
  task automatic build_tables();
    logic [7:0] y, s;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int cand = 1; cand < 256; cand++)
        if (x != 0 && gmul(8'(x), 8'(cand)) == 8'h01) y = 8'(cand);
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      sbox_f[x] = s;
      sbox_i[s] = 8'(x);
    end
  endtask

  // Reference round on a byte array.
  function automatic logic [DL-1:0] model(input logic [DL-1:0] d, input logic [DL-1:0] k,
                                          input logic f);
    logic [7:0] st [16];
    logic [7:0] t  [16];
    logic [7:0] m  [16];
    logic [7:0] cf [4];
    logic [DL-1:0] res;
    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    for (int i = 0; i < 16; i++) st[i] = d[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = sbox_i[st[4*((c-r+4)%4)+r]] ^ k[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        m[4*c+r] = 8'h00;
        for (int j = 0; j < 4; j++) m[4*c+r] = m[4*c+r] ^ gmul(cf[j], t[4*c+(r+j)%4]);
      end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = f ? t[i] : m[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic fin_eff();
`ifdef INV_ROUND_FINAL_EN
    return fin;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: record what the edge accepts, then check outputs on the falling edge.
  task automatic step(input string tag);
    exp_t e;
    exp_t x;
    e.valid = dv && kv;
    e.data  = model(din, key, fin_eff());
    @(posedge clk);
    if (reset) hist.delete();
    else begin
      hist.push_back(e);
      if (hist.size() > 3) void'(hist.pop_front());
    end
    @(negedge clk);
    if (reset) begin
      chk({tag, "_rst_valid"}, DL'(vout), '0);
      chk({tag, "_rst_data"}, dout, '0);
    end else begin
      x.valid = 1'b0;
      x.data  = '0;
      if (hist.size() == 3) x = hist[0];
      chk({tag, "_valid"}, DL'(vout), DL'(x.valid));
      if (x.valid) chk({tag, "_data"}, dout, x.data);
    end
  endtask

  task automatic idle();
    dv = 1'b0; kv = 1'b0; fin = 1'b0;
  endtask

  task automatic beat(input logic [DL-1:0] d, input logic [DL-1:0] k, input logic f);
    dv = 1'b1; kv = 1'b1; din = d; key = k; fin = f;
  endtask

  vec_t       vecs[$];
  logic [6:0] pat;

  initial begin
    build_tables();
    vecs.push_back('{'0, '0, 1'b0, {16{8'h52}}});
    vecs.push_back('{'0, {16{8'hff}}, 1'b0, {16{8'had}}});
    vecs.push_back('{{16{8'h63}}, 128'h01000000_00000000_00000000_00000000, 1'b0,
                     128'h0e090d0b_00000000_00000000_00000000});
    vecs.push_back('{128'h63006363_63636363_63636363_63636363, '0, 1'b0,
                     128'h00000000_5051f4a7_00000000_00000000});
`ifdef INV_ROUND_FINAL_EN
    vecs.push_back('{{16{8'h63}}, 128'h01000000_00000000_00000000_00000000, 1'b1,
                     128'h01000000_00000000_00000000_00000000});
    vecs.push_back('{128'h63006363_63636363_63636363_63636363, '0, 1'b1,
                     128'h00000000_00520000_00000000_00000000});
`endif

    // Reset held with valid stimulus present.
    reset = 1'b1;
    din = {4{$urandom}}; key = {4{$urandom}};
    dv = 1'b1; kv = 1'b1; fin = 1'b0;
    repeat (4) step("reset_hold");

    // Beat on the very first edge after release.
    reset = 1'b0;
    beat({4{$urandom}}, {4{$urandom}}, 1'b0);
    step("first_edge");
    idle();
    repeat (3) step("first_edge_drain");

    // Known-answer table.
    foreach (vecs[i]) begin
      beat(vecs[i].data, vecs[i].key, vecs[i].fin);
      step("vec_in");
      idle();
      repeat (2) step("vec_wait");
      chk($sformatf("vec%0d_valid", i), DL'(vout), DL'(1));
      chk($sformatf("vec%0d_data", i), dout, vecs[i].exp);
      step("vec_tail");
    end

    // Single-sided valids are ignored.
    dv = 1'b1; kv = 1'b0; din = {4{$urandom}}; key = {4{$urandom}};
    step("dv_only");
    dv = 1'b0; kv = 1'b1;
    step("kv_only");
    idle();
    repeat (3) step("half_drain");

    // 4 beats, 2-cycle gap, 1 beat: output pattern 1111001.
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4 || i == 6) beat({4{$urandom}}, {4{$urandom}}, 1'b0);
      else idle();
      step("burst");
      if (i >= 2 && i <= 8) pat[6-(i-2)] = vout;
    end
    chk("burst_pattern", DL'(pat), DL'(7'b1111001));

    // Reset one cycle after accepting a beat discards it.
    beat({4{$urandom}}, {4{$urandom}}, 1'b0);
    step("mid_beat");
    idle();
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    repeat (5) step("mid_after");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      dv    = ($urandom_range(0, 3) != 0);
      kv    = ($urandom_range(0, 3) != 0);
      din   = {$urandom, $urandom, $urandom, $urandom};
      key   = {$urandom, $urandom, $urandom, $urandom};
      fin   = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    reset = 1'b0;
    idle();
    repeat (4) step("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
